// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parameterised register file: clear-FSM
// state encoding and the address-width helper.
package regfile_param_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clearState_t;

    // Smallest n with 2**n >= value; used to size address fields.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Bus bundle for the register file: one write port, two read ports,
// the sweep-clear request and the status outputs.
interface regfile_param_if
    import regfile_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = clog2(DEPTH);

    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readAddress1;
    logic [ADDR_W-1:0] readAddress2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              clearReq;
    logic              busy;
    logic              writeDrop;

    modport master (
        output writeEnable, writeAddress, writeData,
        output readAddress1, readAddress2, clearReq,
        input  readData1, readData2, busy, writeDrop
    );

    modport slave (
        input  writeEnable, writeAddress, writeData,
        input  readAddress1, readAddress2, clearReq,
        output readData1, readData2, busy, writeDrop
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Background sweep-clear sequencer: walks a pointer over every entry,
// one per cycle, and tells the storage which entry to zero.
module regfile_clear_seq
    import regfile_param_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clearReq,
    output logic                     busy,
    output logic                     clearEn,
    output logic [clog2(DEPTH)-1:0]  clearIdx
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clearState_t       state;
    clearState_t       stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;

    // State and pointer registers; reset returns to an idle sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
        end
    end

    // Next-state logic; the last entry's clear and the return to idle happen together.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        case (state)
            IDLE: begin
                if (clearReq) begin
                    stateNext = SWEEP;
                    ptrNext   = '0;
                end
            end
            SWEEP: begin
                ptrNext = ptr + ADDR_W'(1);
                if (ptr == LAST_IDX) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                ptrNext   = '0;
            end
        endcase
    end

    // Outputs are purely a function of the current state and pointer.
    always_comb begin
        busy     = (state == SWEEP);
        clearEn  = (state == SWEEP);
        clearIdx = ptr;
    end

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with one write port, two combinational read
// ports, optional write-to-read forwarding and a background sweep-clear.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 1
)(
    input  logic           clk,
    input  logic           rst,
    regfile_param_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              clearEn;
    logic [ADDR_W-1:0] clearIdx;
    logic              writeAccept;
    logic              writeDropReg;

    regfile_clear_seq #(
        .DEPTH(DEPTH)
    ) clearSeq (
        .clk      (clk),
        .rst      (rst),
        .clearReq (bus.clearReq),
        .busy     (busy),
        .clearEn  (clearEn),
        .clearIdx (clearIdx)
    );

    assign writeAccept   = bus.writeEnable && !busy && !rst;
    assign bus.busy      = busy;
    assign bus.writeDrop = writeDropReg;

    // Storage update: reset wipes everything, then sweep clearing, then normal writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clearEn) begin
            mem[clearIdx] <= '0;
        end else if (writeAccept) begin
            mem[bus.writeAddress] <= bus.writeData;
        end
    end

    // Flag writes that arrived while the sweep owned the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeDropReg <= 1'b0;
        end else begin
            writeDropReg <= bus.writeEnable && busy;
        end
    end

    // Read ports: optional forwarding of the accepted write, forced to zero during a sweep.
    always_comb begin
        bus.readData1 = mem[bus.readAddress1];
        bus.readData2 = mem[bus.readAddress2];
        if (BYPASS != 0 && writeAccept) begin
            if (bus.readAddress1 == bus.writeAddress) begin
                bus.readData1 = bus.writeData;
            end
            if (bus.readAddress2 == bus.writeAddress) begin
                bus.readData2 = bus.writeData;
            end
        end
        if (busy) begin
            bus.readData1 = '0;
            bus.readData2 = '0;
        end
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W SHALL default to 8 and set the entry width in bits.
REQ-002 Parameter DEPTH SHALL default to 16 and set the entry count; legal values are powers of two, 2 to 256.
REQ-003 Parameter BYPASS SHALL default to 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 Local constant ADDR_W SHALL equal clog2(DEPTH) and is not overridable.
REQ-005 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide, and is a synchronous, active-high reset.
REQ-007 Port writeEnable SHALL be an input, 1 bit wide, and requests a write this cycle.
REQ-008 Port writeAddress SHALL be an input, ADDR_W bits wide, and gives the write index.
REQ-009 Port writeData SHALL be an input, DATA_W bits wide, and gives the write value.
REQ-010 Ports readAddress1 and readAddress2 SHALL be inputs, ADDR_W bits each, and give the two independent read indices.
REQ-011 Ports readData1 and readData2 SHALL be outputs, DATA_W bits each, and return combinational read data.
REQ-012 Port clearReq SHALL be an input, 1 bit wide, and requests a background sweep-clear.
REQ-013 Port busy SHALL be an output, 1 bit wide, and is high while the sweep is active.
REQ-014 Port writeDrop SHALL be an output, 1 bit wide, and is a registered one-cycle pulse marking a rejected write.

Function
REQ-015 Storage SHALL be DEPTH entries of DATA_W bits; every address in 0..DEPTH-1 is fully writable, with no truncation of width or depth.
REQ-016 A write with writeEnable=1, busy=0 and rst=0 SHALL update entry[writeAddress] at the rising edge.
REQ-017 With BYPASS=0, reads SHALL return entry[readAddress] combinationally; the same-cycle write is visible in the next cycle.
REQ-018 With BYPASS=1, when writeEnable=1, busy=0, rst=0 and readAddressN==writeAddress, readDataN SHALL equal writeData in the same cycle.
REQ-019 Clear FSM SHALL have states IDLE and SWEEP, plus an ADDR_W-bit pointer ptr.
REQ-020 IDLE to SWEEP SHALL occur on clearReq=1; ptr loads 0; busy is driven high from the next cycle.
REQ-021 In SWEEP, each cycle SHALL zero entry[ptr] and increment ptr; the FSM returns to IDLE after entry DEPTH-1 is cleared, so the sweep takes exactly DEPTH cycles.
REQ-022 busy SHALL equal (state==SWEEP).
REQ-023 clearReq asserted while in SWEEP SHALL be ignored; it neither restarts nor extends the sweep.
REQ-024 A write attempted while busy=1 SHALL be discarded, and writeDrop SHALL pulse high in the following cycle.
REQ-025 While busy=1, readData1 and readData2 SHALL return 0 regardless of address.
REQ-026 If clearReq and writeEnable are both high in IDLE, the write SHALL complete and the sweep then starts, so the write is subsequently cleared.
REQ-027 Reads while idle SHALL be unaffected by clearReq.
REQ-028 ptr wrap from DEPTH-1 to 0 SHALL coincide with the SWEEP to IDLE transition; no extra cycle occurs.

Reset
REQ-029 rst=1 at a rising edge SHALL zero all DEPTH entries in that cycle, force state to IDLE, set ptr=0, busy=0 and writeDrop=0.
REQ-030 rst SHALL take priority over an in-progress sweep, writeEnable and clearReq; a write in a reset cycle is lost and does not raise writeDrop.
REQ-031 After reset, readData1 and readData2 SHALL read 0 for every address.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=0, SWEEP=1) and the clog2 helper.
REQ-033 The clear FSM and pointer SHALL live in the sub-module regfile_clear_seq, which outputs busy, the clear enable and the clear index.
REQ-034 The storage array, write port, bypass muxes and read-zero gating SHALL stay in regfile_param.

Verification
REQ-035 Basic write/read: with defaults, write 0xA5 to address 3 and 0x3C to address 15, then read addresses 3 and 15 on the two ports -> 0xA5 and 0x3C.
REQ-036 Bypass: with BYPASS=1, writeEnable=1, writeAddress=7, writeData=0x5A and readAddress1=7 -> readData1=0x5A in the same cycle; with BYPASS=0, the old value that cycle and 0x5A next cycle.
REQ-037 Sweep: fill all 16 entries with 0xFF, pulse clearReq -> busy high for exactly 16 cycles, reads are 0 during the sweep, and all entries read 0 afterwards.
REQ-038 Blocked write: during the sweep, write 0x11 to address 2 -> writeDrop pulses one cycle later, and address 2 reads 0 after the sweep.
REQ-039 Reset mid-sweep: assert rst at sweep cycle 5 -> busy=0 next cycle, all entries 0, and a following write of 0x77 to address 4 reads back 0x77.
REQ-040 Parameter sweep: with DATA_W=32 and DEPTH=64, write 0xDEADBEEF to address 63 and read it back; a clear then takes 64 cycles.
